load_store_unit: RTL and testbench

//   Initiator side of the CPU data-memory interface. Accepts one load or store request

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the CPU data-memory port.
// One request in flight at a time. Sub-word stores do a read-modify-write
// because the memory has no byte enables. Loads return extended lane data.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;      // word to write (plain or merged)
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic              req_mis;
  logic [4:0]        shamt;
  logic [31:0]       lane_mask;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic [31:0]       load_ext;

  // Alignment check on the incoming request.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      SZ_BYTE: req_mis = 1'b0;
      SZ_HALF: req_mis = req_addr[0];
      SZ_WORD: req_mis = (req_addr[1:0] != 2'b00);
      default: req_mis = 1'b1;
    endcase
  end

  // Lane selection, store merge and load extension for the registered request.
  always_comb begin
    shamt      = (size_q == SZ_HALF) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    lane_mask  = (size_q == SZ_HALF) ? (32'h0000_FFFF << shamt) : (32'h0000_00FF << shamt);
    lane_wdata = (size_q == SZ_HALF) ? {16'h0, wdata_q[15:0]} : {24'h0, wdata_q[7:0]};
    lane_wdata = lane_wdata << shamt;
    lane_rdata = mem_data_out >> shamt;
    load_ext   = mem_data_out;
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h0, lane_rdata[7:0]}
                                     : {{24{lane_rdata[7]}}, lane_rdata[7:0]};
      SZ_HALF: load_ext = unsigned_q ? {16'h0, lane_rdata[15:0]}
                                     : {{16{lane_rdata[15]}}, lane_rdata[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (req_mis) begin
            // Abort without touching memory.
            rdata_d = 32'h0;
            mis_d   = 1'b1;
            state_d = RESP;
          end else if (req_write && req_size == SZ_WORD) begin
            word_d  = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        if (write_q) begin
          word_d  = (mem_data_out & ~lane_mask) | (lane_wdata & lane_mask);
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          mis_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = 32'h0;
        mis_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partially issued access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      rdata_q    <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
    end
  end

  // Outputs decode straight from state so each enable lasts exactly one state.
  always_comb begin
    req_ready        = (state_q == IDLE);
    mem_read_enable  = (state_q == RD);
    mem_write_enable = (state_q == WR);
    mem_data_in      = (state_q == WR) ? word_q : 32'h0;
    resp_valid       = (state_q == RESP);
    resp_rdata       = rdata_q;
    resp_misaligned  = mis_q;
    mem_address      = 32'(addr_q >> 2);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a synchronous word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_data_out;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write and registered read on the rising edge.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_q = 32'h0;
  assign mem_data_out = rd_q;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_data_in;
    if (mem_read_enable)  rd_q <= mem[mem_address[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          re_at;   // expected read-pulse cycle, -1 if none
    int          we_at;   // expected write-pulse cycle, -1 if none
    int          nrd;
    int          nwr;
    logic [31:0] idx;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic prev_re = 1'b0;
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus monitor: enable rules, pulse timing/address and response scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_re = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (mem_read_enable || mem_write_enable) begin
        chk("en_both", {31'h0, mem_read_enable && mem_write_enable}, 32'h0);
        chk("re_consec", {31'h0, mem_read_enable && prev_re}, 32'h0);
        chk("we_consec", {31'h0, mem_write_enable && prev_we}, 32'h0);
        if (sb.size() == 0) chk("stray_en", 32'h1, 32'h0);
        else begin
          chk("mem_addr", mem_address, sb[0].idx);
          if (mem_read_enable)  chk("re_cyc", cyc - sb[0].acc, sb[0].re_at);
          if (mem_write_enable) chk("we_cyc", cyc - sb[0].acc, sb[0].we_at);
        end
      end
      if (mem_read_enable)  rd_cnt++;
      if (mem_write_enable) wr_cnt++;
      prev_re = mem_read_enable;
      prev_we = mem_write_enable;
      if (resp_valid) begin
        if (sb.size() == 0) chk("stray_resp", 32'h1, 32'h0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("misaligned", {31'h0, resp_misaligned}, {31'h0, e.mis});
          chk("latency", cyc - e.acc, e.lat);
          chk("n_reads", rd_cnt, e.nrd);
          chk("n_writes", wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Builds the expected outcome and updates the reference memory for stores.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd, input bit upd);
    exp_t e;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    e.idx = {2'b00, a[31:2]};
    e.rdata = 32'h0;
    e.mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.acc = 0;
    if (e.mis) begin
      e.lat = 1; e.re_at = -1; e.we_at = -1; e.nrd = 0; e.nwr = 0;
    end else if (wr) begin
      if (sz == 2'b10) begin
        e.lat = 2; e.re_at = -1; e.we_at = 1; e.nrd = 0; e.nwr = 1;
        if (upd) ref_mem[e.idx[7:0]] = wd;
      end else begin
        e.lat = 4; e.re_at = 1; e.we_at = 3; e.nrd = 1; e.nwr = 1;
        w = ref_mem[e.idx[7:0]];
        if (sz == 2'b00) w[8*a[1:0] +: 8] = wd[7:0];
        else             w[16*a[1] +: 16] = wd[15:0];
        if (upd) ref_mem[e.idx[7:0]] = w;
      end
    end else begin
      e.lat = 3; e.re_at = 1; e.we_at = -1; e.nrd = 1; e.nwr = 0;
      w = ref_mem[e.idx[7:0]];
      b = w[8*a[1:0] +: 8];
      h = w[16*a[1] +: 16];
      case (sz)
        2'b00:   e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
        2'b01:   e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
        default: e.rdata = w;
      endcase
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit hold = 0, input bit aborted = 0);
    exp_t e;
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'h0, 32'h1);
    end else begin
      e = model(wr, sz, uns, a, wd, !aborted);
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_we", {31'h0, mem_write_enable}, 32'h0);
    chk("rst_re", {31'h0, mem_read_enable}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_din", mem_data_in, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mis", {31'h0, resp_misaligned}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Word store then load back.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h10, 32'h0);
    drain();
    chk("sw_mem", mem[4], 32'hDEADBEEF);

    // Byte store read-modify-write.
    issue(1, 2'b10, 0, 32'h20, 32'h11223344);
    issue(1, 2'b00, 0, 32'h21, 32'h000000AA);
    issue(0, 2'b10, 0, 32'h20, 32'h0);
    drain();
    chk("sb_mem", mem[8], 32'h1122AA44);

    // Sign and zero extension.
    issue(1, 2'b10, 0, 32'h30, 32'h000080F0);
    issue(0, 2'b00, 0, 32'h30, 32'h0);
    issue(0, 2'b00, 1, 32'h30, 32'h0);
    issue(0, 2'b01, 0, 32'h30, 32'h0);
    issue(0, 2'b01, 1, 32'h30, 32'h0);
    issue(0, 2'b00, 0, 32'h31, 32'h0);
    issue(0, 2'b01, 0, 32'h32, 32'h0);
    issue(1, 2'b01, 0, 32'h32, 32'h0000BEEF);
    issue(0, 2'b10, 0, 32'h30, 32'h0);
    drain();

    // Misaligned and illegal-size requests.
    issue(0, 2'b10, 0, 32'h02, 32'h0);
    issue(1, 2'b01, 0, 32'h03, 32'h1234);
    issue(0, 2'b11, 0, 32'h00, 32'h0);
    issue(1, 2'b10, 0, 32'h41, 32'hCAFEF00D);
    drain();
    chk("mis_no_write", mem[16], 32'h0);

    // Reset in RD_WAIT of a byte store: no write, no response.
    issue(1, 2'b00, 0, 32'h20, 32'h00000055, 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_reads", rd_cnt, 1);
    chk("abort_writes", wr_cnt, 0);
    rd_cnt = 0;
    wr_cnt = 0;
    void'(sb.pop_front());
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_mem", mem[8], 32'h1122AA44);

    // Back-to-back with req_valid held.
    issue(1, 2'b10, 0, 32'h50, 32'h89ABCDEF, 1);
    issue(0, 2'b10, 0, 32'h50, 32'h0, 1);
    issue(1, 2'b00, 0, 32'h53, 32'h00000012, 1);
    issue(1, 2'b01, 0, 32'h50, 32'h00003456, 1);
    issue(0, 2'b10, 0, 32'h50, 32'h0, 1);
    issue(0, 2'b00, 0, 32'h20, 32'h0, 0);
    drain();

    // Random traffic in a small window.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 32'h60 + 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();
    for (int i = 24; i < 32; i++) chk("rand_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
